// File: rtl/cm0_dap_dp_arb.sv
// Arbitrates two DP-side requesters onto the DP->AP 4-phase transfer channel,
// returning read data/error to the winner and bounding each transfer by timeout or host abort.
module cm0_dap_dp_arb #(
  parameter int unsigned TOUT_W = 8,
  parameter bit          FIXPRI = 1'b0
) (
  input  logic        swclktck,
  input  logic        dpreset_n,
  input  logic        req0_valid,
  input  logic        req0_rnw,
  input  logic [3:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  input  logic        req1_valid,
  input  logic        req1_rnw,
  input  logic [3:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        abort_i,
  output logic        dp_req_o,
  output logic        dp_rnw_o,
  output logic [3:0]  dp_regaddr_o,
  output logic [31:0] dp_data_o,
  input  logic        ap_ack_i,
  input  logic [31:0] ap_data_i,
  input  logic        ap_err_i,
  output logic        tout_sticky_o
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [TOUT_W-1:0] CNT_MAX  = '1;
  // Counter becomes all-ones as the wait ends, bounding each wait to 2**TOUT_W-1 cycles.
  localparam logic [TOUT_W-1:0] CNT_LAST = CNT_MAX - TOUT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_REL   = 3'd2,
    S_RSP   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                winner_q, winner_d;
  logic                rr_q, rr_d;
  logic [TOUT_W-1:0]   cnt_q, cnt_d;
  logic                dp_req_q, dp_req_d;
  logic                dp_rnw_q, dp_rnw_d;
  logic [ADDR_W-1:0]   dp_addr_q, dp_addr_d;
  logic [DATA_W-1:0]   dp_data_q, dp_data_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;
  logic                cap_err_q, cap_err_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                sticky_q, sticky_d;

  logic                ready0_c, ready1_c;
  logic                pick1_c;
  logic                tout_hit_c;
  logic [TOUT_W-1:0]   cnt_inc_c;

  // Port 1 wins only when port 0 is absent or round-robin currently favours it.
  assign pick1_c    = req1_valid && (!req0_valid || (!FIXPRI && rr_q));
  assign tout_hit_c = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TOUT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    dp_rnw_d   = dp_rnw_q;
    dp_addr_d  = dp_addr_q;
    dp_data_d  = dp_data_q;
    cap_data_d = cap_data_q;
    cap_err_d  = cap_err_q;
    sticky_d   = sticky_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    rdata_d    = '0;
    err_d      = 1'b0;
    ready0_c   = 1'b0;
    ready1_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A stale ack from an earlier transfer blocks new grants until it falls.
        if (!ap_ack_i && (req0_valid || req1_valid)) begin
          ready0_c   = !pick1_c;
          ready1_c   = pick1_c;
          winner_d   = pick1_c;
          dp_rnw_d   = pick1_c ? req1_rnw   : req0_rnw;
          dp_addr_d  = pick1_c ? req1_addr  : req0_addr;
          dp_data_d  = pick1_c ? req1_wdata : req0_wdata;
          cap_data_d = '0;
          cap_err_d  = 1'b0;
          cnt_d      = '0;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        cnt_d = cnt_inc_c;
        if (abort_i || tout_hit_c) begin
          cap_data_d = '0;
          cap_err_d  = 1'b1;
          sticky_d   = sticky_q | tout_hit_c;
          cnt_d      = '0;
          state_d    = S_DRAIN;
        end else if (ap_ack_i) begin
          cap_data_d = ap_data_i;
          cap_err_d  = ap_err_i;
          cnt_d      = '0;
          state_d    = S_REL;
        end
      end

      S_REL: begin
        cnt_d = cnt_inc_c;
        if (abort_i || tout_hit_c) begin
          cap_data_d = '0;
          cap_err_d  = 1'b1;
          sticky_d   = sticky_q | tout_hit_c;
          cnt_d      = '0;
          state_d    = S_DRAIN;
        end else if (!ap_ack_i) begin
          state_d = S_RSP;
        end
      end

      S_DRAIN: begin
        cnt_d = cnt_inc_c;
        if (!ap_ack_i) begin
          state_d = S_RSP;
        end else if (tout_hit_c) begin
          sticky_d = 1'b1;
          state_d  = S_RSP;
        end
      end

      S_RSP: begin
        rr_d    = ~winner_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response outputs are registered so they are valid exactly during RSP.
    if (state_d == S_RSP) begin
      done0_d = !winner_d;
      done1_d = winner_d;
      err_d   = cap_err_d;
      rdata_d = (dp_rnw_q && !cap_err_d) ? cap_data_d : '0;
    end
  end

  assign dp_req_d = (state_d == S_REQ);

  always_ff @(posedge swclktck) begin
    if (!dpreset_n) begin
      state_q    <= S_IDLE;
      winner_q   <= 1'b0;
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      dp_req_q   <= 1'b0;
      dp_rnw_q   <= 1'b0;
      dp_addr_q  <= '0;
      dp_data_q  <= '0;
      cap_data_q <= '0;
      cap_err_q  <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      dp_req_q   <= dp_req_d;
      dp_rnw_q   <= dp_rnw_d;
      dp_addr_q  <= dp_addr_d;
      dp_data_q  <= dp_data_d;
      cap_data_q <= cap_data_d;
      cap_err_q  <= cap_err_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
    end
  end

  assign req0_ready    = ready0_c;
  assign req1_ready    = ready1_c;
  assign req0_done     = done0_q;
  assign req1_done     = done1_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign dp_req_o      = dp_req_q;
  assign dp_rnw_o      = dp_rnw_q;
  assign dp_regaddr_o  = dp_addr_q;
  assign dp_data_o     = dp_data_q;
  assign tout_sticky_o = sticky_q;

  // Channel payload must not move while the AP may be sampling it.
  a_payload_stable: assert property (@(posedge swclktck) disable iff (!dpreset_n)
    (dp_req_q && $past(dp_req_q)) |-> $stable({dp_rnw_q, dp_addr_q, dp_data_q}));

  a_done_onehot: assert property (@(posedge swclktck) disable iff (!dpreset_n)
    !(done0_q && done1_q));

  a_done_in_rsp: assert property (@(posedge swclktck) disable iff (!dpreset_n)
    (done0_q || done1_q) |-> (state_q == S_RSP));

endmodule

// File: tb/tb_cm0_dap_dp_arb.sv
// Self-checking bench for cm0_dap_dp_arb: vector table plus hand-built abort,
// timeout, arbitration and reset sequences, checked through a completion scoreboard.
module tb_cm0_dap_dp_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        dpreset_n = 1'b0;
  logic        req0_valid = 1'b0, req0_rnw = 1'b0;
  logic [3:0]  req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req0_ready, req0_done;
  logic        req1_valid = 1'b0, req1_rnw = 1'b0;
  logic [3:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req1_ready, req1_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        abort_i = 1'b0;
  logic        dp_req_o, dp_rnw_o;
  logic [3:0]  dp_regaddr_o;
  logic [31:0] dp_data_o;
  logic        ap_ack_i, ap_err_i;
  logic [31:0] ap_data_i;
  logic        tout_sticky_o;

  // fixed-priority instance used for the arbitration comparison
  logic        fp_v0 = 1'b0, fp_v1 = 1'b0;
  logic        fp_ready0, fp_ready1, fp_done0, fp_done1, fp_err;
  logic [31:0] fp_rdata, fp_data;
  logic        fp_req, fp_rnw, fp_sticky;
  logic [3:0]  fp_addr;
  logic        fp_ack = 1'b0;

  cm0_dap_dp_arb #(.TOUT_W(4), .FIXPRI(1'b0)) dut (
    .swclktck(clk), .dpreset_n(dpreset_n),
    .req0_valid(req0_valid), .req0_rnw(req0_rnw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_rnw(req1_rnw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .abort_i(abort_i),
    .dp_req_o(dp_req_o), .dp_rnw_o(dp_rnw_o), .dp_regaddr_o(dp_regaddr_o), .dp_data_o(dp_data_o),
    .ap_ack_i(ap_ack_i), .ap_data_i(ap_data_i), .ap_err_i(ap_err_i), .tout_sticky_o(tout_sticky_o)
  );

  cm0_dap_dp_arb #(.TOUT_W(4), .FIXPRI(1'b1)) dut_fp (
    .swclktck(clk), .dpreset_n(dpreset_n),
    .req0_valid(fp_v0), .req0_rnw(req0_rnw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(fp_ready0), .req0_done(fp_done0),
    .req1_valid(fp_v1), .req1_rnw(req1_rnw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(fp_ready1), .req1_done(fp_done1),
    .rsp_rdata(fp_rdata), .rsp_err(fp_err), .abort_i(abort_i),
    .dp_req_o(fp_req), .dp_rnw_o(fp_rnw), .dp_regaddr_o(fp_addr), .dp_data_o(fp_data),
    .ap_ack_i(fp_ack), .ap_data_i(32'h0F0F_0000), .ap_err_i(1'b0), .tout_sticky_o(fp_sticky)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // AP model: mode 0 auto-ack after ap_dly edges, 1 never acks, 2 bench-driven
  int          ap_mode = 0;
  int          ap_dly = 1;
  int          ap_wait = 0;
  logic [31:0] ap_rdata_v = '0;
  logic        ap_err_v = 1'b0;
  logic        ack_auto = 1'b0, err_auto = 1'b0;
  logic [31:0] data_auto = '0;
  logic        ack_man = 1'b0, err_man = 1'b0;
  logic [31:0] data_man = '0;

  assign ap_ack_i  = (ap_mode == 2) ? ack_man  : ack_auto;
  assign ap_data_i = (ap_mode == 2) ? data_man : data_auto;
  assign ap_err_i  = (ap_mode == 2) ? err_man  : err_auto;

  always @(posedge clk) begin
    if (ap_mode != 0) begin
      ack_auto <= 1'b0;
      ap_wait  <= 0;
    end else if (dp_req_o && !ack_auto) begin
      if (ap_wait >= ap_dly - 1) begin
        ack_auto  <= 1'b1;
        data_auto <= ap_rdata_v;
        err_auto  <= ap_err_v;
      end else begin
        ap_wait <= ap_wait + 1;
      end
    end else if (!dp_req_o && ack_auto) begin
      ack_auto <= 1'b0;
      ap_wait  <= 0;
    end
  end

  always @(posedge clk) begin
    if (!dpreset_n)             fp_ack <= 1'b0;
    else if (fp_req && !fp_ack) fp_ack <= 1'b1;
    else if (!fp_req && fp_ack) fp_ack <= 1'b0;
  end

  typedef struct packed {
    logic        port;
    logic        rnw;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   exp_len = 0;
  int   run_len = 0;
  logic req_prev = 1'b0;

  // Monitor: payload at request rise, request length at fall, completions vs scoreboard
  always @(negedge clk) begin
    if (!dpreset_n) begin
      run_len  = 0;
      req_prev = 1'b0;
    end else begin
      if (dp_req_o && !req_prev && sb.size() > 0) begin
        chk("dp_rnw", 32'(dp_rnw_o), 32'(sb[0].rnw));
        chk("dp_regaddr", 32'(dp_regaddr_o), 32'(sb[0].addr));
        if (!sb[0].rnw) chk("dp_data", dp_data_o, sb[0].wdata);
      end
      if (dp_req_o) begin
        run_len = run_len + 1;
      end else if (req_prev) begin
        if (exp_len != 0) chk("req_len", 32'(run_len), 32'(exp_len));
        run_len = 0;
      end
      req_prev = dp_req_o;
      if (req0_done || req1_done) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none at %0t",
                   req0_done, req1_done, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("done_port", 32'({req1_done, req0_done}), mon_e.port ? 32'd2 : 32'd1);
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end
    end
  end

  task automatic push_exp(input logic port, input logic rnw, input logic [3:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.port = port; e.rnw = rnw; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic port, input logic rnw, input logic [3:0] addr, input logic [31:0] wdata);
    if (port) begin
      req1_valid = 1'b1; req1_rnw = rnw; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = 1'b1; req0_rnw = rnw; req0_addr = addr; req0_wdata = wdata;
    end
  endtask

  task automatic wait_ready(input logic port, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = port ? req1_ready : req0_ready;
    end
    if (!ok) fail_to(nm);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (sb.size() == 0);
    end
    if (!ok) begin
      fail_to(nm);
      sb.delete();
    end
  endtask

  task automatic xfer(input logic port, input logic rnw, input logic [3:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int len);
    push_exp(port, rnw, addr, wdata, exp_rdata, exp_err);
    exp_len = len;
    drive_req(port, rnw, addr, wdata);
    wait_ready(port, "xfer_ready");
    wait_drain("xfer_done");
  endtask

  task automatic do_reset();
    dpreset_n  = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; fp_v0 = 1'b0; fp_v1 = 1'b0;
    abort_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dpreset_n = 1'b1;
    sb.delete();
  endtask

  typedef struct {
    logic        port;
    logic        rnw;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] ap_rdata;
    logic        ap_err;
    int          dly;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem0, rem1, frem0, frem1, fidx;

    vt[0] = '{1'b0, 1'b1, 4'h4, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 2, 32'hDEAD_BEEF, 1'b0};
    vt[1] = '{1'b1, 1'b0, 4'h8, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1, 32'h0000_0000, 1'b0};
    vt[2] = '{1'b0, 1'b0, 4'h2, 32'hAAAA_0001, 32'h5555_5555, 1'b1, 1, 32'h0000_0000, 1'b1};
    vt[3] = '{1'b1, 1'b1, 4'hC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 3, 32'hCAFE_F00D, 1'b0};
    vt[4] = '{1'b0, 1'b1, 4'h0, 32'h0000_0000, 32'h0000_0001, 1'b1, 1, 32'h0000_0000, 1'b1};
    vt[5] = '{1'b1, 1'b1, 4'hF, 32'h0000_0000, 32'hA5A5_5A5A, 1'b0, 1, 32'hA5A5_5A5A, 1'b0};

    do_reset();
    @(negedge clk);
    chk("reset_dp_data", dp_data_o, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_ctl", 32'({dp_req_o, dp_rnw_o, dp_regaddr_o, req0_done, req1_done, rsp_err,
                          tout_sticky_o, req0_ready, req1_ready}), 32'h0);
    @(posedge clk); #1;

    // table: reads, writes, AP error, varying ack latency
    for (int i = 0; i < 6; i++) begin
      ap_mode = 0; ap_dly = vt[i].dly; ap_rdata_v = vt[i].ap_rdata; ap_err_v = vt[i].ap_err;
      xfer(vt[i].port, vt[i].rnw, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err, vt[i].dly + 1);
    end

    // arbitration from reset: round-robin alternates, fixed priority drains port 0 first
    do_reset();
    ap_mode = 0; ap_dly = 1; ap_rdata_v = 32'h1111_2222; ap_err_v = 1'b0; exp_len = 2;
    req0_rnw = 1'b1; req0_addr = 4'h6; req0_wdata = '0;
    req1_rnw = 1'b1; req1_addr = 4'h6; req1_wdata = '0;
    for (int i = 0; i < 8; i++) push_exp(1'((i % 2) == 1), 1'b1, 4'h6, 32'h0, 32'h1111_2222, 1'b0);
    rem0 = 4; rem1 = 4; frem0 = 4; frem1 = 4; fidx = 0;
    for (int c = 0; c < 300 && (sb.size() > 0 || fidx < 8); c++) begin
      req0_valid = (rem0 > 0); req1_valid = (rem1 > 0);
      fp_v0 = (frem0 > 0); fp_v1 = (frem1 > 0);
      @(negedge clk);
      if (req0_ready) rem0--;
      if (req1_ready) rem1--;
      if (fp_ready0)  frem0--;
      if (fp_ready1)  frem1--;
      if (fp_done0 || fp_done1) begin
        chk("fp_order", 32'({fp_done1, fp_done0}), (fidx < 4) ? 32'd1 : 32'd2);
        chk("fp_rdata", fp_rdata, 32'h0F0F_0000);
        fidx++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; fp_v0 = 1'b0; fp_v1 = 1'b0;
    chk("rr_pending", 32'(sb.size()), 32'd0);
    chk("fp_count", 32'(fidx), 32'd8);
    chk("fp_latched", 32'({fp_req, fp_rnw, fp_addr, fp_sticky}), 32'({1'b0, 1'b1, 4'h6, 1'b0}));
    chk("fp_data", fp_data, 32'h0);
    sb.delete();

    // AP never acks: timeout after 15 cycles in REQ
    chk("sticky_before", 32'(tout_sticky_o), 32'd0);
    ap_mode = 1;
    xfer(1'b0, 1'b1, 4'h3, 32'h0, 32'h0, 1'b1, 15);
    chk("sticky_after", 32'(tout_sticky_o), 32'd1);

    // abort three cycles into REQ, same cycle as ack rises
    ap_mode = 2; ack_man = 1'b0;
    push_exp(1'b0, 1'b1, 4'h5, 32'h0, 32'h0, 1'b1);
    exp_len = 3;
    drive_req(1'b0, 1'b1, 4'h5, 32'h0);
    wait_ready(1'b0, "t5_ready");
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort_i = 1'b1; ack_man = 1'b1; data_man = 32'h7777_7777; err_man = 1'b0;
    @(posedge clk); #1;
    abort_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_drain_req", 32'(dp_req_o), 32'd0);
      chk("t5_no_done", 32'(req0_done), 32'd0);
      @(posedge clk); #1;
    end
    ack_man = 1'b0;
    wait_drain("t5_done");
    chk("t5_sticky_kept", 32'(tout_sticky_o), 32'd1);

    // reset during REL, then stale ack holds off the next grant
    exp_len = 0;
    drive_req(1'b1, 1'b0, 4'h9, 32'h9999_0000);
    wait_ready(1'b1, "t6_ready");
    ack_man = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rel_req", 32'(dp_req_o), 32'd0);
    dpreset_n = 1'b0;
    @(posedge clk); #1;
    dpreset_n = 1'b1;
    push_exp(1'b1, 1'b0, 4'hA, 32'h0BAD_F00D, 32'h0, 1'b0);
    drive_req(1'b1, 1'b0, 4'hA, 32'h0BAD_F00D);
    @(negedge clk);
    chk("t6_rst_data", dp_data_o, 32'h0);
    chk("t6_rst_ctl", 32'({dp_req_o, dp_rnw_o, dp_regaddr_o, req0_done, req1_done, rsp_err,
                           tout_sticky_o}), 32'h0);
    chk("t6_rst_rdata", rsp_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_stale_block", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    ack_man = 1'b0;
    @(negedge clk);
    chk("t6_grant", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    ap_mode = 0; ap_dly = 1; ap_rdata_v = 32'h0; ap_err_v = 1'b0; exp_len = 2;
    wait_drain("t6_done");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
